// File: rtl/lab7soc_pio_pkg.sv
// Shared constants and state type for the lab7soc PIO output-register bank.
package lab7soc_pio_pkg;

    // Control-space register indices (address MSB set)
    localparam int IDX_CTRL = 0;
    localparam int IDX_FCNT = 1;

    // CTRL/STATUS bit positions
    localparam int COMMIT   = 0;
    localparam int IMM      = 1;
    localparam int IRQEN    = 2;
    localparam int IRQCLR   = 3;
    localparam int STAT_IRQ = 4;

    typedef enum logic {
        IDLE,
        PENDING
    } pio_state_t;

endpackage

// File: rtl/lab7soc_pio_bank_ch.sv
// One channel of the PIO bank: a software-visible shadow word and the
// active word that drives the fabric, loaded from shadow on commit.
module lab7soc_pio_bank_ch #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  commit,
    output logic [DATA_W-1:0]     shadow,
    output logic [DATA_W-1:0]     active
);

    // Active takes the pre-write shadow value, so a same-cycle write waits for the next commit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (commit) begin
                active <= shadow;
            end
            if (wr_en) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (byteenable[b]) begin
                        shadow[b*8 +: 8] <= writedata[b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lab7soc_pio_bank.sv
// Avalon-MM output-register bank with shadow/active copies that are swapped
// atomically on a frame-sync edge (or immediately on request), plus a
// commit counter and a commit-done interrupt.
module lab7soc_pio_bank
    import lab7soc_pio_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NUM_CH = 4,
    localparam int ADDR_W = $clog2(NUM_CH) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [DATA_W-1:0]          writedata,
    input  logic [DATA_W/8-1:0]        byteenable,
    output logic [DATA_W-1:0]          readdata,
    input  logic                       frame_sync,
    output logic [NUM_CH*DATA_W-1:0]   out_port,
    output logic                       update_pulse,
    output logic                       irq
);

    localparam int IDX_W = ADDR_W - 1;

    logic              wr;
    logic              ctrl_sel;
    logic [IDX_W-1:0]  idx;
    logic              ctrl_wr;
    logic              imm_wr;
    logic              req_wr;
    logic              sync_q;
    logic              frame_edge;
    logic              commit;
    logic              irq_en;
    logic              irq_flag;
    logic [DATA_W-1:0] frame_count;
    logic [DATA_W-1:0] shadow_w [NUM_CH];
    pio_state_t        state;
    pio_state_t        state_n;

    assign wr         = chipselect & ~write_n;
    assign ctrl_sel   = address[ADDR_W-1];
    assign idx        = address[IDX_W-1:0];
    assign ctrl_wr    = wr & ctrl_sel & (idx == IDX_W'(IDX_CTRL));
    assign imm_wr     = ctrl_wr & writedata[IMM];
    assign req_wr     = ctrl_wr & writedata[COMMIT];
    assign frame_edge = frame_sync & ~sync_q;
    assign commit     = ((state == PENDING) & frame_edge) | imm_wr;
    assign irq        = irq_flag & irq_en;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_ch
            lab7soc_pio_bank_ch #(
                .DATA_W(DATA_W)
            ) u_ch (
                .clk        (clk),
                .reset_n    (reset_n),
                .wr_en      (wr & ~ctrl_sel & (idx == IDX_W'(k))),
                .byteenable (byteenable),
                .writedata  (writedata),
                .commit     (commit),
                .shadow     (shadow_w[k]),
                .active     (out_port[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Commit state register; reset discards any pending commit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A commit always returns to IDLE; a request made in an edge cycle waits for the next edge
    always_comb begin
        state_n = state;
        if (commit) begin
            state_n = IDLE;
        end else if (req_wr) begin
            state_n = PENDING;
        end
    end

    // Edge history, commit counter, strobe and interrupt bookkeeping; a commit beats IRQ_CLR
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q       <= 1'b0;
            irq_en       <= 1'b0;
            irq_flag     <= 1'b0;
            frame_count  <= '0;
            update_pulse <= 1'b0;
        end else begin
            sync_q       <= frame_sync;
            update_pulse <= commit;
            if (ctrl_wr) begin
                irq_en <= writedata[IRQEN];
            end
            if (commit) begin
                irq_flag    <= 1'b1;
                frame_count <= frame_count + 1'b1;
            end else if (ctrl_wr & writedata[IRQCLR]) begin
                irq_flag <= 1'b0;
            end
        end
    end

    // Zero-wait read mux: shadow words below the MSB, status and counter above it
    always_comb begin
        readdata = '0;
        if (!ctrl_sel) begin
            readdata = shadow_w[idx];
        end else if (idx == IDX_W'(IDX_CTRL)) begin
            readdata[COMMIT]   = (state == PENDING);
            readdata[IRQEN]    = irq_en;
            readdata[STAT_IRQ] = irq_flag;
        end else if (idx == IDX_W'(IDX_FCNT)) begin
            readdata = frame_count;
        end
    end

endmodule

// File: doc/lab7soc_pio_bank.md
# lab7soc_pio_bank

Parametrised Avalon-MM output-register bank that succeeds the single-word PIO slaves in the lab7soc SoC. It holds NUM_CH software-writable shadow words and drives the fabric from a separate active copy. The active copy is updated atomically on a frame-sync edge, so the raycaster never sees a half-updated player/camera state. It also provides a commit handshake, a frame counter and an interrupt.

## Interface
- DATA_W, 32: word width; multiple of 8.
- NUM_CH, 4: channel count; power of two, ≥2.
- ADDR_W, clog2(NUM_CH)+1: address width (derived, not overridden).
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- address  in  ADDR_W  MSB=0: shadow channel address[ADDR_W-2:0]; MSB=1: control space.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  DATA_W  write data.
- byteenable  in  DATA_W/8  per-byte write enable; applies to shadow writes only.
- readdata  out  DATA_W  zero-wait-state read data (combinational from address).
- frame_sync  in  1  frame boundary level from the VGA controller, already in the clk domain.
- out_port  out  NUM_CH*DATA_W  active words; channel k at [k*DATA_W +: DATA_W].
- update_pulse  out  1  one-cycle strobe when active words change.
- irq  out  1  commit-done interrupt, level.

## Operation
- Control space (MSB=1), by index:
  - 0 CTRL/STATUS, write:
    - bit0 COMMIT_REQ: sets pending.
    - bit1 IMMEDIATE: commit next cycle, ignoring frame_sync.
    - bit2 IRQ_EN: stored.
    - bit3 IRQ_CLR: write-1 clears the irq flag.
  - 0 CTRL/STATUS, read: bit0 pending, bit2 IRQ_EN, bit4 irq flag, others 0.
  - 1 FRAME_COUNT: read-only count of commits, wraps at 2^DATA_W.
  - Other indices: read 0, writes ignored.
- Write = chipselect & ~write_n. Shadow bytes update only where byteenable=1.
- Shadow reads return the shadow word, not the active word.
- States:
  - IDLE→PENDING on a COMMIT_REQ write.
  - PENDING→IDLE on commit.
  - An IMMEDIATE write commits from either state and leaves IDLE.
- Edge: edge = frame_sync & ~sync_q, where sync_q is frame_sync registered.
- Commit condition: (PENDING & edge) | IMMEDIATE write.
- Commit actions:
  - active ← shadow, all channels, using shadow values registered before this cycle.
  - FRAME_COUNT += 1.
  - irq flag ← 1.
  - update_pulse is asserted.
- irq = flag & IRQ_EN. The flag is cleared only by IRQ_CLR or reset.
- Simultaneous events:
  - Shadow write in the commit cycle: not included in this commit; it remains in shadow.
  - COMMIT_REQ write in an edge cycle while IDLE: goes PENDING and waits for the next edge.
  - COMMIT_REQ while already PENDING: no effect.
  - IRQ_CLR in the same cycle as a commit: set wins; flag = 1.
- Reset: shadow, active, sync_q, pending, IRQ_EN, flag and FRAME_COUNT all 0. out_port, update_pulse and irq are 0. A pending commit is discarded.

## Timing
- Write accepted at edge N → visible on readdata and STATUS from cycle N+1.
- Frame commit: first cycle with frame_sync high (previous low) = E, with pending. Then out_port, update_pulse, irq, FRAME_COUNT and cleared pending all appear in E+1. update_pulse is high for exactly one cycle.
- IMMEDIATE write at N → out_port updated at N+1.
- frame_sync held high for many cycles gives one edge only. A new edge needs frame_sync low for ≥1 cycle.
- readdata has no registered latency: it reflects state after the previous edge.

## Structure
- Package lab7soc_pio_pkg holds:
  - Control indices: IDX_CTRL=0, IDX_FCNT=1.
  - CTRL bit positions: COMMIT=0, IMM=1, IRQEN=2, IRQCLR=3, STAT_IRQ=4.
  - State enum: IDLE, PENDING.
- Sub-module lab7soc_pio_bank_ch: one shadow/active word pair with byteenable write and commit load. Generated NUM_CH times.
- Top level holds address decode, FSM, edge detect, counter, irq and the read mux.

## Test plan
- Reset: drive reset_n low for 2 cycles, then read all addresses → all 0; out_port=0, irq=0.
- Byte-enable write: write ch1=0xAABBCCDD, then write 0x11223344 with byteenable=4'b0101 → ch1 reads 0xAA22CC44; out_port unchanged.
- Frame commit: write ch0..3 = 1,2,3,4; COMMIT_REQ; frame_sync 0→1 at E → out_port = {4,3,2,1} at E+1; update_pulse for one cycle; FRAME_COUNT=1; STATUS bit0=0.
- No pending: frame_sync edge with pending=0 → out_port and FRAME_COUNT unchanged; update_pulse stays 0.
- Collision: shadow write ch0=9 in cycle E of a commit → active ch0 keeps the old value; shadow ch0=9; the next commit delivers 9.
- IRQ path: set IRQ_EN, then IMMEDIATE → irq=1 next cycle. Write IRQ_CLR in the same cycle as a frame commit → irq stays 1. A later IRQ_CLR alone → irq=0.
